// File: rtl/lsu_data_memory.sv
// Load/store data memory for the SEQ core: sized little-endian accesses with byte-lane
// stores, sign/zero-extended loads, error flags and a stallable fixed-depth read pipeline.
module lsu_data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_out_of_range
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready.
  // req_ready equals adv (= !rsp_valid || rsp_ready), so a stalled response freezes the
  // whole pipeline and blocks new requests; a response is consumed on rsp_valid && rsp_ready.

  logic [63:0] r_mem [DEPTH_WORDS];

  logic          r_valid [LATENCY];
  logic [63:0]   r_rdata [LATENCY];
  logic          r_mis   [LATENCY];
  logic          r_oor   [LATENCY];

  logic          w_adv;
  logic          w_accept;
  logic [AW-1:0] w_index;
  logic [2:0]    w_offset;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_error;
  logic [7:0]    w_lane_mask;
  logic [7:0]    w_byte_mask;
  logic [63:0]   w_bit_mask;
  logic [63:0]   w_wdata_shifted;
  logic [63:0]   w_word;
  logic [63:0]   w_shifted;
  logic [63:0]   w_load_data;
  logic [63:0]   w_stage_rdata;

  assign w_adv     = !r_valid[LATENCY-1] || rsp_ready;
  assign req_ready = w_adv;
  assign w_accept  = req_valid && w_adv && !reset;

  assign w_index  = req_addr[AW+2:3];
  assign w_offset = req_addr[2:0];

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Misalignment masks the range flag so only one error is ever reported.
  assign w_out_of_range = !w_misaligned && (|req_addr[63:AW+3]);
  assign w_error        = w_misaligned || w_out_of_range;

  always_comb begin
    w_lane_mask = 8'hFF;
    case (req_size)
      2'b00:   w_lane_mask = 8'h01;
      2'b01:   w_lane_mask = 8'h03;
      2'b10:   w_lane_mask = 8'h0F;
      default: w_lane_mask = 8'hFF;
    endcase
  end

  assign w_byte_mask     = w_lane_mask << w_offset;
  assign w_wdata_shifted = req_wdata << {w_offset, 3'b000};

  always_comb begin
    w_bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_bit_mask[8*i +: 8] = {8{w_byte_mask[i]}};
    end
  end

  // Array has no reset; stores land on the acceptance edge only when error-free.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_error) begin
      r_mem[w_index] <= (r_mem[w_index] & ~w_bit_mask) | (w_wdata_shifted & w_bit_mask);
    end
  end

  // Combinational read, captured on the acceptance edge, so later stores cannot leak in.
  assign w_word    = r_mem[w_index];
  assign w_shifted = w_word >> {w_offset, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (req_size)
      2'b00: w_load_data = req_unsigned ? {56'd0, w_shifted[7:0]}
                                        : {{56{w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_load_data = req_unsigned ? {48'd0, w_shifted[15:0]}
                                        : {{48{w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_load_data = req_unsigned ? {32'd0, w_shifted[31:0]}
                                        : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  assign w_stage_rdata = (w_accept && !req_write && !w_error) ? w_load_data : 64'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_valid[i] <= 1'b0;
        r_rdata[i] <= 64'd0;
        r_mis[i]   <= 1'b0;
        r_oor[i]   <= 1'b0;
      end
    end else if (w_adv) begin
      r_valid[0] <= w_accept;
      r_rdata[0] <= w_stage_rdata;
      r_mis[0]   <= w_accept && w_misaligned;
      r_oor[0]   <= w_accept && w_out_of_range;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_rdata[i] <= r_rdata[i-1];
        r_mis[i]   <= r_mis[i-1];
        r_oor[i]   <= r_oor[i-1];
      end
    end
  end

  assign rsp_valid        = r_valid[LATENCY-1];
  assign rsp_rdata        = r_rdata[LATENCY-1];
  assign rsp_misaligned   = r_mis[LATENCY-1];
  assign rsp_out_of_range = r_oor[LATENCY-1];

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: directed scenarios plus random traffic checked against a
// byte-array reference model with an in-order expected-response queue.
module tb_lsu_data_memory;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_out_of_range;

  lsu_data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .rsp_out_of_range(rsp_out_of_range)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0]  ref_mem [DEPTH*8];
  logic [63:0] exp_q [$];
  logic [1:0]  exp_flags_q [$];
  int          acc_cyc_q [$];
  int          acc_stall_q [$];
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          stalls;
  logic        fresh;
  logic        prev_stall;
  logic [63:0] prev_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: applies a request to the byte array and returns the response.
  task automatic model_accept(input logic w, input logic [1:0] sz, input logic u,
                              input logic [63:0] a, input logic [63:0] wd,
                              output logic [63:0] rd, output logic [1:0] flags);
    int   nb;
    logic mis;
    logic oor;
    nb  = 1 << sz;
    mis = (a % 64'(nb)) != 0;
    oor = !mis && ((a >> 3) >= 64'(DEPTH));
    rd  = 64'd0;
    if (!mis && !oor) begin
      if (w) begin
        for (int b = 0; b < nb; b++) ref_mem[int'(a) + b] = wd[8*b +: 8];
      end else begin
        for (int b = 0; b < nb; b++) rd = rd | (64'(ref_mem[int'(a) + b]) << (8*b));
        if (nb < 8 && !u && rd[8*nb-1]) rd = rd | ({64{1'b1}} << (8*nb));
      end
    end
    flags = {mis, oor};
  endtask

  // Drive one cycle of inputs, observe/score at the falling edge, then pass the rising edge.
  task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                      input logic [63:0] a, input logic [63:0] wd, input logic rr);
    logic        exp_ready;
    logic [63:0] rd;
    logic [1:0]  fl;
    req_valid = v; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; rsp_ready = rr;
    @(negedge clk);
    exp_ready = !rsp_valid || rr;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (prev_stall) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", rsp_rdata, prev_rdata);
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        if (fresh)
          check("latency", 64'(cyc - acc_cyc_q[0] - (stalls - acc_stall_q[0])), 64'(LAT));
        if (rr) begin
          check("rdata", rsp_rdata, exp_q[0]);
          check("misaligned", 64'(rsp_misaligned), 64'(exp_flags_q[0][1]));
          check("out_of_range", 64'(rsp_out_of_range), 64'(exp_flags_q[0][0]));
          void'(exp_q.pop_front());
          void'(exp_flags_q.pop_front());
          void'(acc_cyc_q.pop_front());
          void'(acc_stall_q.pop_front());
        end
      end
    end
    if (v && exp_ready) begin
      model_accept(w, sz, u, a, wd, rd, fl);
      exp_q.push_back(rd);
      exp_flags_q.push_back(fl);
      acc_cyc_q.push_back(cyc);
      acc_stall_q.push_back(stalls);
    end
    prev_stall = rsp_valid && !rr;
    prev_rdata = rsp_rdata;
    if (prev_stall) stalls++;
    fresh = !rsp_valid || rr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [63:0] a, input logic rr);
    step(1'b1, 1'b0, sz, u, a, 64'd0, rr);
  endtask

  task automatic store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    step(1'b1, 1'b1, sz, 1'b0, a, wd, 1'b1);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 64'd0, 64'd0, rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(LAT + 1, 1'b1);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    exp_flags_q.delete();
    acc_cyc_q.delete();
    acc_stall_q.delete();
    fresh = 1'b1;
    prev_stall = 1'b0;
  endtask

  // Assert reset mid-cycle with a store presented; neither it nor in-flight loads survive.
  task automatic mid_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11;
    req_addr = 64'h100; req_wdata = 64'hDEAD_BEEF_0BAD_F00D; rsp_ready = 1'b1;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_flags", {62'd0, rsp_misaligned, rsp_out_of_range}, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    clear_scoreboard();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    int          nb;
    n_tests = 0; n_fail = 0; cyc = 0; stalls = 0;
    clear_scoreboard();
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
    #3;
    check("init_rsp_valid", 64'(rsp_valid), 64'd0);
    check("init_req_ready", 64'(req_ready), 64'd1);
    check("init_rdata", rsp_rdata, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) store(2'b11, 64'(i*8), {$urandom, $urandom});
    drain();

    // Doubleword store, signed/unsigned byte loads, half-word lane store.
    store(2'b11, 64'h40, 64'h8877665544332211);
    load(2'b00, 1'b0, 64'h47, 1'b1);
    load(2'b00, 1'b1, 64'h47, 1'b1);
    store(2'b01, 64'h42, 64'h0000_0000_0000_BEEF);
    load(2'b11, 1'b0, 64'h40, 1'b1);
    drain();
    check("dw_model", {ref_mem[71], ref_mem[70], ref_mem[69], ref_mem[68],
                       ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]},
          64'h88776655BEEF2211);

    // Error cases.
    load(2'b10, 1'b0, 64'h42, 1'b1);
    store(2'b11, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF);
    load(2'b11, 1'b0, 64'h0, 1'b1);
    load(2'b11, 1'b0, 64'(DEPTH*8), 1'b1);
    load(2'b11, 1'b0, 64'(DEPTH*8 + 3), 1'b1);
    load(2'b00, 1'b1, 64'(DEPTH*8 + 3), 1'b1);
    drain();

    // Reset with three loads in flight, first response already visible.
    load(2'b11, 1'b0, 64'h08, 1'b1);
    load(2'b11, 1'b0, 64'h10, 1'b1);
    load(2'b11, 1'b0, 64'h18, 1'b1);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    mid_reset();
    idle(LAT + 2, 1'b1);
    load(2'b11, 1'b0, 64'h100, 1'b1);
    drain();

    // Backpressure: A, B, C then three stall cycles with a blocked request presented.
    load(2'b11, 1'b0, 64'h08, 1'b1);
    load(2'b10, 1'b0, 64'h14, 1'b1);
    load(2'b01, 1'b1, 64'h1E, 1'b1);
    for (int i = 0; i < 3; i++) load(2'b11, 1'b0, 64'h20, 1'b0);
    drain();

    // A load stalled in the pipeline must not see a younger store to the same address.
    load(2'b11, 1'b0, 64'h80, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0, 64'h80, 64'h1, 1'b0);
    idle(LAT + 3, 1'b0);
    drain();
    load(2'b11, 1'b0, 64'h80, 1'b1);
    drain();
    check("order_model", 64'(ref_mem[128]), 64'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = 64'($urandom_range(0, DEPTH*8 + 31));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      if ($urandom_range(0, 31) == 0) a = {$urandom, $urandom};
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4), sz,
           1'($urandom_range(0, 1)), a, {$urandom, $urandom},
           1'($urandom_range(0, 9) < 7));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
